pulp_boot_seq: RTL and testbench
================================

// Module: pulp_boot_seq
// PURPOSE
//  Boot sequencer between the PS control registers, clk_rst_gen and the PULPino core. On a run request it holds
//  PULPino in reset and programs the clocking wizard over AXI-lite: CLKOUT0 divide, then load. It polls the
//  wizard's lock bit, releases PULPino reset, waits a settle time, then asserts fetch enable.
// PARAMETERS
//  SETTLE_CYCLES  16       cycles from reset release to fetch_en_o high (>=1)
//  POLL_TIMEOUT   4096     max status polls before error (used with BOOT_SEQ_TIMEOUT_EN)
//  DIV_ADDR       11'h208  wizard CLKOUT0 divide register
//  LOAD_ADDR      11'h25C  wizard load/SEN register
//  STAT_ADDR      11'h004  wizard status register
//  LOAD_VAL       32'h3    value written to LOAD_ADDR
//  LOCK_BIT       0        bit of the status word that indicates lock
// PORTS
//  clk            in   1   PS reference clock; also the AXI-lite clock
//  rst_n          in   1   asynchronous, active-low reset
//  run_i          in   1   level; 1 = boot and run PULPino, 0 = hold PULPino in reset
//  clk_div_i      in   8   CLKOUT0 divide value; sampled when leaving IDLE
//  m_awaddr/awvalid/awready         out/out/in  11/1/1   AXI-lite write address channel
//  m_wdata/wstrb/wvalid/wready      out/out/out/in 32/4/1/1  AXI-lite write data channel
//  m_bresp/bvalid/bready            in/in/out   2/1/1    AXI-lite write response channel
//  m_araddr/arvalid/arready         out/out/in  11/1/1   AXI-lite read address channel
//  m_rdata/rresp/rvalid/rready      in/in/in/out 32/2/1/1  AXI-lite read data channel
//  pulp_rstn_o    out  1   PULPino reset, active low
//  fetch_en_o     out  1   PULPino fetch enable
//  busy_o         out  1   sequence in progress
//  err_o          out  1   sticky error flag; cleared only when run_i is low in ERR
//  state_o        out  3   current FSM state, for debug
// BEHAVIOUR
//  Reset values: all valid/ready outputs 0, pulp_rstn_o=0, fetch_en_o=0, busy_o=0, err_o=0, state_o=IDLE.
//  States: IDLE, WR_DIV, WR_LOAD, RD_STAT, SETTLE, RUN, ERR.
//  IDLE: if run_i=1, latch clk_div_i and go to WR_DIV.
//  WR_DIV: wdata={24'b0,div}. WR_LOAD: wdata=LOAD_VAL. wstrb is always 4'hF.
//  Write rule: awvalid and wvalid rise together. Each drops in the cycle after its own handshake; the two
//  channels may complete in either order or in the same cycle. bready goes high once both handshakes are
//  done and stays high until bvalid. bresp!=OKAY -> ERR.
//  Read rule: arvalid is held until arready. rready is high after the AR handshake, until rvalid.
//  rresp!=OKAY -> ERR. If rdata[LOCK_BIT]=1 -> SETTLE, otherwise issue another read.
//  SETTLE: pulp_rstn_o=1. A down-counter is loaded with SETTLE_CYCLES-1. At zero -> RUN.
//  RUN: fetch_en_o=1, busy_o=0.
//  busy_o=1 in WR_DIV, WR_LOAD, RD_STAT and SETTLE.
//  run_i=0 during an AXI transaction: the transaction (address, data, response) always completes; no valid
//   is dropped before its handshake. Then go to IDLE.
//  run_i=0 in SETTLE or RUN: go to IDLE next cycle. pulp_rstn_o and fetch_en_o are 0 in that same next cycle.
//  ERR: pulp_rstn_o=0, fetch_en_o=0, err_o=1. Exit to IDLE only when run_i=0.
//  No new AXI request is issued in the cycle that a response is received (no back-to-back AR within 1 cycle).
//  Asynchronous reset mid-transaction drops all valids immediately; the slave is reset by the same PS reset.
// CONFIGURATION
//  BOOT_SEQ_TIMEOUT_EN defined: a poll counter counts RD_STAT reads since entering RD_STAT. When it reaches
//   POLL_TIMEOUT without lock, the FSM goes to ERR.
//  BOOT_SEQ_TIMEOUT_EN not defined: the FSM polls without limit; the poll counter is not instantiated.
// STRUCTURE
//  Package pulp_boot_seq_pkg: state enum (3-bit), AXI resp constants (OKAY=2'b00), default register addresses.
//  Sub-module axil_single_master: one-transaction AXI-lite master with req/we/addr/wdata -> done/rdata/err.
//   The FSM drives it; it owns all the channel handshakes.
// TESTING
//  1. Slave with zero wait states, clk_div_i=8'h0A, run_i=1 -> writes 0x208=0x0000000A, then 0x25C=0x3.
//     Lock is returned on the 3rd read. pulp_rstn_o rises, then fetch_en_o rises exactly 16 cycles later.
//  2. awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles.
//     One bready/bvalid handshake follows.
//  3. bresp=2'b10 on the write to 0x25C -> ERR, err_o=1, no read issued. run_i 1->0 -> IDLE, err_o=0.
//  4. run_i dropped while arvalid is waiting on arready -> arvalid held until arready, rvalid consumed, then
//     IDLE. pulp_rstn_o stays 0 throughout.
//  5. With BOOT_SEQ_TIMEOUT_EN and POLL_TIMEOUT=8, lock never set -> exactly 8 reads, then ERR.
//     Without the macro, the reads continue beyond 8.
//  6. In RUN, drop run_i for 1 cycle and reassert it -> fetch_en_o=0 in the next cycle, and a full
//     reprogramming sequence starts again.

Source files
------------

// File: rtl/pulp_boot_seq_pkg.sv
// Shared types and constants for the PULPino boot sequencer.
// State encoding is visible on state_o, so the values are fixed.
package pulp_boot_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_DIV  = 3'd1,
      ST_WR_LOAD = 3'd2,
      ST_RD_STAT = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_RUN     = 3'd5,
      ST_ERR     = 3'd6
   } boot_state_e;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

   localparam logic [10:0] DEF_DIV_ADDR  = 11'h208;
   localparam logic [10:0] DEF_LOAD_ADDR = 11'h25C;
   localparam logic [10:0] DEF_STAT_ADDR = 11'h004;
   localparam logic [31:0] DEF_LOAD_VAL  = 32'h3;

endpackage

// File: rtl/pulp_boot_seq_if.sv
// AXI-lite bus between the boot sequencer and the clocking wizard.
interface pulp_boot_seq_if;

   logic [10:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [10:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/pulp_boot_seq_axil_single_master.sv
// One-at-a-time AXI-lite master: accepts req while idle, owns all handshakes,
// pulses done (with err/rdata) in the cycle the response handshake happens.
module axil_single_master
   import pulp_boot_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [10:0] addr,
   input  logic [31:0] wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        active,
   pulp_boot_seq_if.master m
);

   logic aw_done, w_done;
   logic start, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_both;

   assign start   = req && !active;
   assign aw_hs   = m.awvalid && m.awready;
   assign w_hs    = m.wvalid && m.wready;
   assign b_hs    = m.bvalid && m.bready;
   assign ar_hs   = m.arvalid && m.arready;
   assign r_hs    = m.rvalid && m.rready;
   assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

   assign m.wstrb = '1;
   assign done    = b_hs || r_hs;
   assign rdata   = m.rdata;
   assign err     = b_hs ? (m.bresp != AXI_RESP_OKAY) : (r_hs && (m.rresp != AXI_RESP_OKAY));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active    <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         m.awaddr  <= '0;
         m.awvalid <= 1'b0;
         m.wdata   <= '0;
         m.wvalid  <= 1'b0;
         m.bready  <= 1'b0;
         m.araddr  <= '0;
         m.arvalid <= 1'b0;
         m.rready  <= 1'b0;
      end else begin
         if (start) begin
            active <= 1'b1;
            if (we) begin
               m.awvalid <= 1'b1;
               m.wvalid  <= 1'b1;
               m.awaddr  <= addr;
               m.wdata   <= wdata;
            end else begin
               m.arvalid <= 1'b1;
               m.araddr  <= addr;
            end
         end
         // AW and W retire independently; bready waits for both, whatever the order
         if (aw_hs) begin
            m.awvalid <= 1'b0;
            aw_done   <= 1'b1;
         end
         if (w_hs) begin
            m.wvalid <= 1'b0;
            w_done   <= 1'b1;
         end
         if (wr_both && !m.bready) m.bready <= 1'b1;
         if (b_hs) begin
            m.bready <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            active   <= 1'b0;
         end
         if (ar_hs) begin
            m.arvalid <= 1'b0;
            m.rready  <= 1'b1;
         end
         if (r_hs) begin
            m.rready <= 1'b0;
            active   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pulp_boot_seq.sv
// Boot sequencer: programs the clocking wizard, waits for lock, releases PULPino.
// Optional BOOT_SEQ_TIMEOUT_EN bounds the number of lock polls.
module pulp_boot_seq
   import pulp_boot_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned POLL_TIMEOUT  = 4096,
   parameter logic [10:0] DIV_ADDR      = DEF_DIV_ADDR,
   parameter logic [10:0] LOAD_ADDR     = DEF_LOAD_ADDR,
   parameter logic [10:0] STAT_ADDR     = DEF_STAT_ADDR,
   parameter logic [31:0] LOAD_VAL      = DEF_LOAD_VAL,
   parameter int unsigned LOCK_BIT      = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_i,
   input  logic [7:0]  clk_div_i,
   pulp_boot_seq_if.master m,
   output logic        pulp_rstn_o,
   output logic        fetch_en_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [2:0]  state_o
);

   localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   boot_state_e          state_q, state_d, ok_st;
   logic                 bus_st;
   logic [7:0]           div_q;
   logic [SETTLE_W-1:0]  settle_q;
   logic                 axi_req, axi_we, axi_done, axi_err, axi_active;
   logic [10:0]          axi_addr;
   logic [31:0]          axi_wdata, axi_rdata;
   logic                 lock, poll_limit;

   assign lock = |(axi_rdata & (32'd1 << LOCK_BIT));

   axil_single_master u_axil (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (axi_req),
      .we     (axi_we),
      .addr   (axi_addr),
      .wdata  (axi_wdata),
      .done   (axi_done),
      .rdata  (axi_rdata),
      .err    (axi_err),
      .active (axi_active),
      .m      (m)
   );

`ifdef BOOT_SEQ_TIMEOUT_EN
   localparam int unsigned POLL_W = $clog2(POLL_TIMEOUT + 1);
   logic [POLL_W-1:0] poll_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    poll_q <= '0;
      else if (state_q != ST_RD_STAT) poll_q <= '0;
      else if (axi_done)             poll_q <= poll_q + 1'b1;
   end

   assign poll_limit = (poll_q == POLL_W'(POLL_TIMEOUT - 1));
`else
   assign poll_limit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         settle_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && run_i) div_q <= clk_div_i;
         // preloaded outside SETTLE so the count is ready on entry
         if (state_q != ST_SETTLE) settle_q <= SETTLE_W'(SETTLE_CYCLES - 1);
         else                      settle_q <= settle_q - 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      ok_st     = state_q;
      bus_st    = 1'b0;
      axi_req   = 1'b0;
      axi_we    = 1'b0;
      axi_addr  = '0;
      axi_wdata = '0;
      case (state_q)
         ST_IDLE:    if (run_i) state_d = ST_WR_DIV;
         ST_WR_DIV: begin
            bus_st    = 1'b1;
            axi_we    = 1'b1;
            axi_addr  = DIV_ADDR;
            axi_wdata = {24'b0, div_q};
            ok_st     = ST_WR_LOAD;
         end
         ST_WR_LOAD: begin
            bus_st    = 1'b1;
            axi_we    = 1'b1;
            axi_addr  = LOAD_ADDR;
            axi_wdata = LOAD_VAL;
            ok_st     = ST_RD_STAT;
         end
         ST_RD_STAT: begin
            bus_st   = 1'b1;
            axi_addr = STAT_ADDR;
            ok_st    = lock ? ST_SETTLE : (poll_limit ? ST_ERR : ST_RD_STAT);
         end
         ST_SETTLE: begin
            if (!run_i)               state_d = ST_IDLE;
            else if (settle_q == '0)  state_d = ST_RUN;
         end
         ST_RUN:     if (!run_i) state_d = ST_IDLE;
         ST_ERR:     if (!run_i) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      // an issued transaction always finishes; run_i=0 only aborts before issue
      if (bus_st) begin
         axi_req = run_i;
         if (axi_done)                   state_d = axi_err ? ST_ERR : (!run_i ? ST_IDLE : ok_st);
         else if (!axi_active && !run_i) state_d = ST_IDLE;
      end
   end

   assign pulp_rstn_o = (state_q == ST_SETTLE) || (state_q == ST_RUN);
   assign fetch_en_o  = (state_q == ST_RUN);
   assign busy_o      = (state_q == ST_WR_DIV) || (state_q == ST_WR_LOAD) ||
                        (state_q == ST_RD_STAT) || (state_q == ST_SETTLE);
   assign err_o       = (state_q == ST_ERR);
   assign state_o     = state_q;

endmodule

// File: tb/tb_pulp_boot_seq.sv
// Directed bench for pulp_boot_seq with a configurable AXI-lite wizard model.
module tb_pulp_boot_seq;
   import pulp_boot_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run_i = 1'b0;
   logic [7:0] clk_div_i = 8'h00;
   logic       pulp_rstn_o, fetch_en_o, busy_o, err_o;
   logic [2:0] state_o;

   pulp_boot_seq_if bus();

   pulp_boot_seq #(
      .SETTLE_CYCLES (16),
      .POLL_TIMEOUT  (8),
      .DIV_ADDR      (11'h208),
      .LOAD_ADDR     (11'h25C),
      .STAT_ADDR     (11'h004),
      .LOAD_VAL      (32'h3),
      .LOCK_BIT      (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (run_i),
      .clk_div_i   (clk_div_i),
      .m           (bus),
      .pulp_rstn_o (pulp_rstn_o),
      .fetch_en_o  (fetch_en_o),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   // slave configuration
   int unsigned aw_delay, ar_delay, lock_read_n;
   logic [10:0] err_addr;

   // slave state and logs
   int unsigned aw_wait, ar_wait, aw_run, w_run;
   bit          aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
   bit          aw_rx, w_rx, r_pend, awv_p, wv_p, arv_p;
   int unsigned aw_n, w_n, b_n, ar_n, r_n, proto_err;
   logic [10:0] aw_addr_log [8];
   logic [31:0] w_data_log  [8];
   int unsigned aw_len_log  [8];
   int unsigned w_len_log   [8];
   logic [10:0] cur_awaddr;
   int unsigned cyc, rstn_rise, fen_rise;
   bit          rstn_seen, rstn_p, fen_p;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Wizard model: acts on the falling edge; the handshakes it flags happen at the next rising edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = AXI_RESP_OKAY;
         bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;    bus.rresp = AXI_RESP_OKAY;
         aw_wait = 0; ar_wait = 0; aw_run = 0; w_run = 0;
         aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
         aw_rx = 0; w_rx = 0; r_pend = 0; awv_p = 0; wv_p = 0; arv_p = 0;
         aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; proto_err = 0;
         cur_awaddr = '0; rstn_rise = 0; fen_rise = 0; rstn_seen = 0; rstn_p = 0; fen_p = 0;
      end else begin
         if (awv_p && !aw_hs_p && !bus.awvalid) proto_err++;
         if (wv_p && !w_hs_p && !bus.wvalid) proto_err++;
         if (arv_p && !ar_hs_p && !bus.arvalid) proto_err++;
         if ((bus.awvalid && !awv_p) != (bus.wvalid && !wv_p)) proto_err++;
         if (r_hs_p && bus.arvalid) proto_err++;

         if (aw_hs_p) begin aw_rx = 1; aw_wait = 0; end
         if (w_hs_p) w_rx = 1;
         if (b_hs_p) begin bus.bvalid = 1'b0; aw_rx = 0; w_rx = 0; b_n++; end
         if (ar_hs_p) begin r_pend = 1; ar_wait = 0; end
         if (r_hs_p) begin bus.rvalid = 1'b0; r_n++; end

         if (bus.awvalid) begin
            aw_run++;
            if (aw_wait >= aw_delay) bus.awready = 1'b1;
            else begin bus.awready = 1'b0; aw_wait++; end
         end else bus.awready = 1'b0;
         bus.wready = bus.wvalid;
         if (bus.wvalid) w_run++;
         if (aw_rx && w_rx && !bus.bvalid) begin
            bus.bvalid = 1'b1;
            bus.bresp  = (cur_awaddr == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
         if (bus.arvalid) begin
            if (ar_wait >= ar_delay) bus.arready = 1'b1;
            else begin bus.arready = 1'b0; ar_wait++; end
         end else bus.arready = 1'b0;
         if (r_pend && !bus.rvalid) begin
            bus.rvalid = 1'b1;
            bus.rdata  = (lock_read_n != 0 && ar_n == lock_read_n) ? 32'hA5A5_0001 : 32'hA5A5_0000;
            r_pend     = 0;
         end

         aw_hs_p = bus.awvalid && bus.awready;
         w_hs_p  = bus.wvalid && bus.wready;
         b_hs_p  = bus.bvalid && bus.bready;
         ar_hs_p = bus.arvalid && bus.arready;
         r_hs_p  = bus.rvalid && bus.rready;
         if (aw_hs_p) begin
            if (aw_n < 8) begin aw_addr_log[aw_n] = bus.awaddr; aw_len_log[aw_n] = aw_run; end
            cur_awaddr = bus.awaddr; aw_n++; aw_run = 0;
         end
         if (w_hs_p) begin
            if (w_n < 8) begin w_data_log[w_n] = bus.wdata; w_len_log[w_n] = w_run; end
            w_n++; w_run = 0;
         end
         if (ar_hs_p) ar_n++;
         awv_p = bus.awvalid; wv_p = bus.wvalid; arv_p = bus.arvalid;

         if (pulp_rstn_o && !rstn_p) rstn_rise = cyc;
         if (fetch_en_o && !fen_p) fen_rise = cyc;
         if (pulp_rstn_o) rstn_seen = 1;
         rstn_p = pulp_rstn_o; fen_p = fetch_en_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int unsigned budget, input string tag);
      int unsigned n = 0;
      while (state_o !== st && n < budget) begin
         tick();
         n++;
      end
      check(tag, {29'b0, state_o}, {29'b0, st});
   endtask

   task automatic restart(input int unsigned awd, input int unsigned ard,
                          input int unsigned lock_n, input logic [10:0] eaddr);
      aw_delay = awd; ar_delay = ard; lock_read_n = lock_n; err_addr = eaddr;
      run_i = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // 1: zero-wait slave, lock on 3rd read, 16-cycle settle
      aw_delay = 0; ar_delay = 0; lock_read_n = 3; err_addr = 11'h7FF;
      clk_div_i = 8'h0A;
      repeat (2) tick();
      check("rst_bus", {27'b0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 32'h0);
      check("rst_ctrl", {28'b0, pulp_rstn_o, fetch_en_o, busy_o, err_o}, 32'h0);
      check("rst_state", {29'b0, state_o}, {29'b0, ST_IDLE});
      rst_n = 1'b1;
      tick();
      run_i = 1'b1;
      tick();
      check("t1_wr_div", {29'b0, state_o}, {29'b0, ST_WR_DIV});
      check("t1_busy", {31'b0, busy_o}, 32'h1);
      wait_state(ST_RUN, 300, "t1_reach_run");
      check("t1_nwrites", aw_n, 2);
      check("t1_div_addr", {21'b0, aw_addr_log[0]}, 32'h208);
      check("t1_div_data", w_data_log[0], 32'h0000_000A);
      check("t1_load_addr", {21'b0, aw_addr_log[1]}, 32'h25C);
      check("t1_load_data", w_data_log[1], 32'h3);
      check("t1_nreads", ar_n, 3);
      check("t1_settle_gap", fen_rise - rstn_rise, 16);
      check("t1_run_ctrl", {28'b0, pulp_rstn_o, fetch_en_o, busy_o, err_o}, 32'b1100);
      check("t1_proto", proto_err, 0);

      // 6: one-cycle run_i drop in RUN restarts the whole sequence
      run_i = 1'b0;
      tick();
      check("t6_fetch_drop", {30'b0, fetch_en_o, pulp_rstn_o}, 32'h0);
      check("t6_idle", {29'b0, state_o}, {29'b0, ST_IDLE});
      clk_div_i = 8'h05;
      lock_read_n = ar_n + 1;
      run_i = 1'b1;
      wait_state(ST_RUN, 300, "t6_rerun");
      check("t6_nwrites", aw_n, 4);
      check("t6_div_addr", {21'b0, aw_addr_log[2]}, 32'h208);
      check("t6_div_data", w_data_log[2], 32'h0000_0005);
      check("t6_load_data", w_data_log[3], 32'h3);
      check("t6_proto", proto_err, 0);

      // 2: awready held off, wready immediate
      restart(2, 0, 1, 11'h7FF);
      clk_div_i = 8'hC3;
      run_i = 1'b1;
      wait_state(ST_RUN, 300, "t2_reach_run");
      check("t2_aw_len", aw_len_log[0], 3);
      check("t2_w_len", w_len_log[0], 1);
      check("t2_aw_len_load", aw_len_log[1], 3);
      check("t2_div_data", w_data_log[0], 32'h0000_00C3);
      check("t2_nresp", b_n, 2);
      check("t2_proto", proto_err, 0);

      // 3: error response on the load write
      restart(0, 0, 1, 11'h25C);
      run_i = 1'b1;
      wait_state(ST_ERR, 200, "t3_err_state");
      check("t3_err_ctrl", {28'b0, pulp_rstn_o, fetch_en_o, busy_o, err_o}, 32'b0001);
      check("t3_no_read", ar_n, 0);
      repeat (5) tick();
      check("t3_err_sticky", {29'b0, state_o}, {29'b0, ST_ERR});
      check("t3_no_read_later", ar_n, 0);
      run_i = 1'b0;
      tick();
      check("t3_idle", {29'b0, state_o}, {29'b0, ST_IDLE});
      check("t3_err_clr", {31'b0, err_o}, 32'h0);

      // 4: run_i dropped while arvalid waits for arready
      restart(0, 4, 1, 11'h7FF);
      run_i = 1'b1;
      for (int i = 0; i < 200 && bus.arvalid !== 1'b1; i++) tick();
      check("t4_arvalid_seen", {31'b0, bus.arvalid}, 32'h1);
      run_i = 1'b0;
      wait_state(ST_IDLE, 50, "t4_idle");
      check("t4_nreads", ar_n, 1);
      check("t4_nresp", r_n, 1);
      check("t4_rstn_low", {31'b0, rstn_seen}, 32'h0);
      repeat (10) tick();
      check("t4_quiet", {ar_n[30:0], bus.arvalid}, 32'h2);
      check("t4_proto", proto_err, 0);

      // 5: lock never reported
      restart(0, 0, 0, 11'h7FF);
      run_i = 1'b1;
`ifdef BOOT_SEQ_TIMEOUT_EN
      wait_state(ST_ERR, 400, "t5_timeout_err");
      check("t5_nreads", ar_n, 8);
      check("t5_nresp", r_n, 8);
      check("t5_err", {31'b0, err_o}, 32'h1);
`else
      repeat (200) tick();
      check("t5_polls_continue", {31'b0, ar_n > 8}, 32'h1);
      check("t5_polling", {29'b0, state_o}, {29'b0, ST_RD_STAT});
      check("t5_no_err", {31'b0, err_o}, 32'h0);
`endif
      check("t5_proto", proto_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
